// File: rtl/if_stage_bpred.sv
// RV32I fetch stage: PC, IF/ID register and a direct-mapped BTB
// with 2-bit saturating counters for next-PC prediction.
module if_stage_bpred #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic        if_id_valid,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc,
  output logic        if_id_pred_taken,
  output logic [31:0] if_id_pred_target
);

  localparam int IDX = $clog2(BTB_ENTRIES);
  localparam int TW  = 30 - IDX;

  logic [31:0] r_pc;
  logic        r_valid;
  logic [31:0] r_instr;
  logic [31:0] r_ipc;
  logic        r_ptaken;
  logic [31:0] r_ptgt;

  logic [BTB_ENTRIES-1:0] r_bv;
  logic [TW-1:0]          r_tag [BTB_ENTRIES];
  logic [29:0]            r_tgt [BTB_ENTRIES];
  logic [1:0]             r_ctr [BTB_ENTRIES];

  logic [IDX-1:0] w_idx;
  logic [TW-1:0]  w_tag;
  logic           w_hit;
  logic           w_ptaken;
  logic [31:0]    w_pnext;
  logic [IDX-1:0] w_uidx;
  logic [TW-1:0]  w_utag;
  logic           w_uhit;
  logic [1:0]     w_uctr;
  logic           w_unused;

  assign w_idx    = r_pc[IDX+1:2];
  assign w_tag    = r_pc[31:IDX+2];
  assign w_hit    = r_bv[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_ptaken = w_hit && r_ctr[w_idx][1];
  assign w_pnext  = w_ptaken ? {r_tgt[w_idx], 2'b00}
                             : r_pc + 32'd4;

  assign w_uidx   = upd_pc[IDX+1:2];
  assign w_utag   = upd_pc[31:IDX+2];
  assign w_uhit   = r_bv[w_uidx] && (r_tag[w_uidx] == w_utag);
  assign w_uctr   = r_ctr[w_uidx];
  assign w_unused = ^{redirect_pc[1:0], upd_pc[1:0],
                      upd_target[1:0]};

  assign imem_addr         = r_pc;
  assign if_id_valid       = r_valid;
  assign if_id_instr       = r_instr;
  assign if_id_pc          = r_ipc;
  assign if_id_pred_taken  = r_ptaken;
  assign if_id_pred_target = r_ptgt;

  // Redirect flushes IF/ID even when the hazard unit is stalling.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= RESET_PC;
      r_valid  <= 1'b0;
      r_instr  <= NOP_INSTR;
      r_ipc    <= 32'd0;
      r_ptaken <= 1'b0;
      r_ptgt   <= 32'd0;
    end else if (redirect_valid) begin
      r_pc    <= {redirect_pc[31:2], 2'b00};
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
    end else if (!stall) begin
      r_pc     <= w_pnext;
      r_valid  <= 1'b1;
      r_instr  <= imem_rdata;
      r_ipc    <= r_pc;
      r_ptaken <= w_ptaken;
      r_ptgt   <= w_pnext;
    end
  end

  // Lookup reads the registered entry, so a same-index update is not seen.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        r_bv[i]  <= 1'b0;
        r_ctr[i] <= 2'b01;
      end
    end else if (upd_valid) begin
      if (w_uhit) begin
        if (upd_taken) begin
          if (w_uctr != 2'b11) r_ctr[w_uidx] <= w_uctr + 2'b01;
          r_tgt[w_uidx] <= upd_target[31:2];
        end else if (w_uctr != 2'b00) begin
          r_ctr[w_uidx] <= w_uctr - 2'b01;
        end
      end else if (upd_taken) begin
        r_bv[w_uidx]  <= 1'b1;
        r_tag[w_uidx] <= w_utag;
        r_tgt[w_uidx] <= upd_target[31:2];
        r_ctr[w_uidx] <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_if_stage_bpred.sv
// Bench for if_stage_bpred: directed fetch/predict scenarios
// followed by random traffic against a behavioural model.
module tb_if_stage_bpred;

  logic        clk = 1'b0;
  logic        rst, stall, redirect_valid;
  logic        upd_valid, upd_taken;
  logic [31:0] redirect_pc, upd_pc, upd_target;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_id_valid, if_id_pred_taken;
  logic [31:0] if_id_instr, if_id_pc, if_id_pred_target;

  always #5 clk = ~clk;

  if_stage_bpred dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
    .if_id_pc(if_id_pc), .if_id_pred_taken(if_id_pred_taken),
    .if_id_pred_target(if_id_pred_target)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_1234;
  endfunction

  assign imem_rdata = mem(imem_addr);

  int checks = 0;
  int errors = 0;

  // Model: fetch state plus a table of branch owners by slot.
  logic [31:0] m_pc, m_ipc, m_instr, m_ptgt;
  bit          m_iv, m_pt;
  bit          b_v   [16];
  logic [31:0] b_own [16];
  logic [31:0] b_tgt [16];
  int          b_ctr [16];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  task automatic model_step();
    int li, ui;
    bit hit, pt;
    logic [31:0] pn, ua;
    if (rst) begin
      m_pc = 32'h0; m_iv = 0; m_instr = 32'h13;
      m_ipc = 0; m_pt = 0; m_ptgt = 0;
      for (int i = 0; i < 16; i++) begin
        b_v[i] = 0; b_ctr[i] = 1;
      end
      return;
    end
    li  = int'((m_pc >> 2) % 16);
    hit = b_v[li] && (b_own[li] == m_pc);
    pt  = hit && (b_ctr[li] >= 2);
    pn  = pt ? b_tgt[li] : m_pc + 32'd4;
    if (redirect_valid) begin
      m_pc = redirect_pc & ~32'h3;
      m_iv = 0; m_instr = 32'h13;
    end else if (!stall) begin
      m_iv = 1; m_instr = mem(m_pc); m_ipc = m_pc;
      m_pt = pt; m_ptgt = pn; m_pc = pn;
    end
    if (upd_valid) begin
      ua = upd_pc & ~32'h3;
      ui = int'((ua >> 2) % 16);
      if (b_v[ui] && b_own[ui] == ua) begin
        if (upd_taken) begin
          b_ctr[ui] = (b_ctr[ui] == 3) ? 3 : b_ctr[ui] + 1;
          b_tgt[ui] = upd_target & ~32'h3;
        end else begin
          b_ctr[ui] = (b_ctr[ui] == 0) ? 0 : b_ctr[ui] - 1;
        end
      end else if (upd_taken) begin
        b_v[ui] = 1; b_own[ui] = ua;
        b_tgt[ui] = upd_target & ~32'h3; b_ctr[ui] = 2;
      end
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit rv,
                     input logic [31:0] rp, input bit uv,
                     input logic [31:0] up, input bit ut,
                     input logic [31:0] utg);
    rst = r; stall = s; redirect_valid = rv; redirect_pc = rp;
    upd_valid = uv; upd_pc = up; upd_taken = ut; upd_target = utg;
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("imem_addr", imem_addr, m_pc);
    chk("valid", {31'd0, if_id_valid}, {31'd0, m_iv});
    chk("instr", if_id_instr, m_instr);
    if (m_iv) begin
      chk("if_id_pc", if_id_pc, m_ipc);
      chk("pred_taken", {31'd0, if_id_pred_taken}, {31'd0, m_pt});
      chk("pred_target", if_id_pred_target, m_ptgt);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic redir(input logic [31:0] a);
    cyc(0, 0, 1, a, 0, 0, 0, 0);
  endtask

  task automatic upd(input logic [31:0] a, input bit t,
                     input logic [31:0] tg);
    cyc(0, 0, 0, 0, 1, a, t, tg);
  endtask

  initial begin
    m_pc = 0; m_iv = 0; m_instr = 32'h13;
    m_ipc = 0; m_pt = 0; m_ptgt = 0;
    // reset state
    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_instr", if_id_instr, 32'h13);
    chk("rst_pc", if_id_pc, 32'h0);
    chk("rst_pt", {31'd0, if_id_pred_taken}, 32'd0);
    chk("rst_ptgt", if_id_pred_target, 32'h0);
    // sequential fetch
    run(1);
    chk("t1_valid", {31'd0, if_id_valid}, 32'd1);
    chk("t1_pc0", if_id_pc, 32'h0);
    run(3);
    chk("t1_pc", if_id_pc, 32'hC);
    // stall at 0x10
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 0, 0);
    chk("t2_addr", imem_addr, 32'h10);
    chk("t2_pc", if_id_pc, 32'hC);
    run(1);
    chk("t2_resume", if_id_pc, 32'h10);
    // allocate 0x20 -> 0x100, then reach it
    upd(32'h20, 1, 32'h100);
    run(3);
    chk("t3_pc", if_id_pc, 32'h20);
    chk("t3_next", imem_addr, 32'h100);
    chk("t3_pt", {31'd0, if_id_pred_taken}, 32'd1);
    chk("t3_ptgt", if_id_pred_target, 32'h100);
    // redirect with stall
    cyc(0, 1, 1, 32'h40, 0, 0, 0, 0);
    chk("t4_addr", imem_addr, 32'h40);
    chk("t4_valid", {31'd0, if_id_valid}, 32'd0);
    chk("t4_instr", if_id_instr, 32'h13);
    run(1);
    chk("t4_first", if_id_pc, 32'h40);
    // saturate down then one taken
    for (int i = 0; i < 4; i++) upd(32'h20, 0, 32'h0);
    upd(32'h20, 1, 32'h100);
    redir(32'h20);
    run(1);
    chk("t5_next", imem_addr, 32'h24);
    chk("t5_pt", {31'd0, if_id_pred_taken}, 32'd0);
    // alias 0x60 evicts 0x20
    upd(32'h60, 1, 32'h180);
    redir(32'h20);
    run(1);
    chk("t6_miss", imem_addr, 32'h24);
    redir(32'h60);
    run(1);
    chk("t6_hit", imem_addr, 32'h180);
    // same-cycle update and lookup sees old entry
    redir(32'h80);
    upd(32'h80, 1, 32'h1C0);
    chk("same_cyc", imem_addr, 32'h84);
    redir(32'h80);
    run(1);
    chk("after_upd", imem_addr, 32'h1C0);
    // alignment and wrap
    redir(32'hFFFF_FFFE);
    chk("align", imem_addr, 32'hFFFF_FFFC);
    run(1);
    chk("wrap", imem_addr, 32'h0);
    // reset dominates everything and clears the BTB
    cyc(1, 1, 1, 32'h44, 1, 32'h60, 1, 32'h1F0);
    chk("rst_dom", imem_addr, 32'h0);
    redir(32'h60);
    run(1);
    chk("rst_clr", imem_addr, 32'h64);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, s, rv, uv, ut;
      logic [31:0] rp, up, tg;
      r  = ($urandom_range(0, 199) == 0);
      s  = ($urandom_range(0, 4) == 0);
      rv = ($urandom_range(0, 9) == 0);
      uv = ($urandom_range(0, 2) == 0);
      ut = $urandom_range(0, 1) == 1;
      rp = ($urandom_range(0, 127) * 4) | $urandom_range(0, 3);
      up = ($urandom_range(0, 127) * 4) | $urandom_range(0, 3);
      tg = ($urandom_range(0, 127) * 4) | $urandom_range(0, 3);
      cyc(r, s, rv, rp, uv, up, ut, tg);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
